// File: rtl/drops_engine.sv
// Falling-drops catch game: a bar on row 0 catches drops that sink down a GS x GS grid.
// Drop columns come from a free-running 8-bit LFSR; the frame output is registered.
module drops_engine #(
    parameter int unsigned GS     = 8,
    parameter int unsigned ND     = 2,
    parameter int unsigned LIVES  = 5,
    parameter int unsigned PERIOD = 4,
    parameter logic [7:0]  SEED   = 8'hA5
) (
    input  logic             clk_i,
    input  logic             reset_ni,
    input  logic             left_i,
    input  logic             right_i,
    input  logic             e_act_i,
    output logic [GS*GS-1:0] matrix_o,
    output logic [7:0]       score_o,
    output logic [3:0]       lives_o,
    output logic             dead_o,
    output logic             d_act_o
);
    localparam int unsigned CW = $clog2(GS);
    typedef logic [CW-1:0] coord_t;

    logic [7:0]       lfsr_q;
    coord_t           bar_q, bar_d;
    logic [ND-1:0]    valid_q, valid_d;
    coord_t           col_q [ND];
    coord_t           col_d [ND];
    coord_t           row_q [ND];
    coord_t           row_d [ND];
    logic [3:0]       fall_q, fall_d;
    logic [3:0]       period_q, period_d;
    logic [3:0]       lives_q, lives_d;
    logic [7:0]       score_q, score_d;
    logic             dead_q, dead_d;
    logic             dact_q;
    logic [GS*GS-1:0] matrix_q, matrix_d;

    logic       step, sink, spawned;
    logic [2:0] n_caught, n_missed;
    logic [8:0] score_sum;

    // Bit col*GS+row is simply {col, row}; ~c equals GS-1-c because GS is a power of two.
    function automatic logic [GS*GS-1:0] diag_frame(input logic with_anti);
        logic [GS*GS-1:0] f;
        coord_t           c;
        f = '0;
        for (int i = 0; i < GS; i++) begin
            c = coord_t'(i);
            f[{c, c}] = 1'b1;
            if (with_anti) f[{c, ~c}] = 1'b1;
        end
        return f;
    endfunction

    always_comb begin
        step      = e_act_i && !dead_q;
        sink      = (fall_q == 4'd0);
        bar_d     = bar_q;
        valid_d   = valid_q;
        col_d     = col_q;
        row_d     = row_q;
        fall_d    = fall_q;
        period_d  = period_q;
        score_d   = score_q;
        lives_d   = lives_q;
        dead_d    = dead_q;
        matrix_d  = matrix_q;
        n_caught  = '0;
        n_missed  = '0;
        spawned   = 1'b0;
        score_sum = '0;
        if (step) begin
            fall_d = sink ? period_q - 4'd1 : fall_q - 4'd1;
            for (int i = 0; i < ND; i++) begin
                // Resolution compares against the bar column before this step's move.
                if (sink && valid_q[i]) begin
                    if (row_q[i] == coord_t'(1)) begin
                        valid_d[i] = 1'b0;
                        if (col_q[i] == bar_q) n_caught = n_caught + 3'd1;
                        else                   n_missed = n_missed + 3'd1;
                    end else begin
                        row_d[i] = row_q[i] - coord_t'(1);
                    end
                end
                // Only slots empty at step start may spawn, so a freed slot waits a step.
                if (!valid_q[i] && !spawned) begin
                    spawned    = 1'b1;
                    valid_d[i] = 1'b1;
                    row_d[i]   = coord_t'(GS - 1);
                    col_d[i]   = lfsr_q[CW-1:0];
                end
            end
            if (left_i && !right_i && bar_q != coord_t'(0)) begin
                bar_d = bar_q - coord_t'(1);
            end else if (right_i && !left_i && bar_q != coord_t'(GS - 1)) begin
                bar_d = bar_q + coord_t'(1);
            end
            score_sum = {1'b0, score_q} + {6'd0, n_caught};
            score_d   = score_sum[8] ? 8'hFF : score_sum[7:0];
            if (score_d != score_q && score_d[2:0] == 3'd0 && period_q > 4'd1) begin
                period_d = period_q - 4'd1;
            end
            lives_d = (lives_q > {1'b0, n_missed}) ? lives_q - {1'b0, n_missed} : 4'd0;
            dead_d  = (lives_d == 4'd0);
            if (dead_d) begin
                matrix_d = diag_frame(1'b1);
            end else begin
                matrix_d = '0;
                matrix_d[{bar_d, coord_t'(0)}] = 1'b1;
                for (int i = 0; i < ND; i++) begin
                    if (valid_d[i]) matrix_d[{col_d[i], row_d[i]}] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            lfsr_q   <= SEED;
            bar_q    <= coord_t'(GS - 1);
            valid_q  <= '0;
            for (int i = 0; i < ND; i++) begin
                col_q[i] <= '0;
                row_q[i] <= '0;
            end
            fall_q   <= 4'(PERIOD - 1);
            period_q <= 4'(PERIOD);
            score_q  <= '0;
            lives_q  <= 4'(LIVES);
            dead_q   <= 1'b0;
            dact_q   <= 1'b0;
            matrix_q <= diag_frame(1'b0);
        end else begin
            lfsr_q   <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
            bar_q    <= bar_d;
            valid_q  <= valid_d;
            col_q    <= col_d;
            row_q    <= row_d;
            fall_q   <= fall_d;
            period_q <= period_d;
            score_q  <= score_d;
            lives_q  <= lives_d;
            dead_q   <= dead_d;
            dact_q   <= step;
            matrix_q <= matrix_d;
        end
    end

    assign matrix_o = matrix_q;
    assign score_o  = score_q;
    assign lives_o  = lives_q;
    assign dead_o   = dead_q;
    assign d_act_o  = dact_q;

endmodule

// File: tb/tb_drops_engine.sv
// Scoreboard bench for drops_engine: a behavioural game model queues the expected frame per
// step and a negedge monitor pops and compares it whenever d_act_o pulses.
module tb_drops_engine;
    localparam int GS     = 8;
    localparam int ND     = 2;
    localparam int LIVES  = 3;
    localparam int PERIOD = 2;
    localparam logic [7:0]  SEED = 8'hA5;
    localparam logic [63:0] DIAG = 64'h8040201008040201;
    localparam logic [63:0] XPAT = 64'h8142241818244281;
    localparam logic [63:0] ROW0 = 64'h0101010101010101;
    localparam logic [63:0] MID  = 64'h7E7E7E7E7E7E7E7E;

    typedef struct {
        logic [63:0] frame;
        logic [7:0]  score;
        logic [3:0]  lives;
        logic        dead;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_ni = 1'b0;
    logic        left = 1'b0;
    logic        right = 1'b0;
    logic        e_act = 1'b0;
    logic [63:0] matrix_o;
    logic [7:0]  score_o;
    logic [3:0]  lives_o;
    logic        dead_o;
    logic        d_act_o;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    exp_t mon_x;

    // Game model
    int          m_bar, m_fall, m_period, m_score, m_lives;
    bit          m_dead;
    bit          m_valid[ND];
    int          m_col[ND];
    int          m_row[ND];
    logic [7:0]  m_lfsr;
    logic [63:0] m_frame;

    drops_engine #(.GS(GS), .ND(ND), .LIVES(LIVES), .PERIOD(PERIOD)) dut (
        .clk_i    (clk),
        .reset_ni (reset_ni),
        .left_i   (left),
        .right_i  (right),
        .e_act_i  (e_act),
        .matrix_o (matrix_o),
        .score_o  (score_o),
        .lives_o  (lives_o),
        .dead_o   (dead_o),
        .d_act_o  (d_act_o)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] lfsr_next(input logic [7:0] l);
        return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    endfunction

    task automatic model_reset();
        m_bar = GS - 1; m_fall = PERIOD - 1; m_period = PERIOD;
        m_score = 0; m_lives = LIVES; m_dead = 0; m_lfsr = SEED; m_frame = DIAG;
        for (int i = 0; i < ND; i++) begin
            m_valid[i] = 0; m_col[i] = 0; m_row[i] = 0;
        end
    endtask

    task automatic model_step(input logic l, input logic r);
        bit was_valid[ND];
        bit sink, done;
        int caught, missed, ns;
        sink = (m_fall == 0);
        m_fall = sink ? m_period - 1 : m_fall - 1;
        caught = 0; missed = 0; done = 0;
        for (int i = 0; i < ND; i++) was_valid[i] = m_valid[i];
        if (sink) begin
            for (int i = 0; i < ND; i++) begin
                if (m_valid[i] && m_row[i] == 1) begin
                    if (m_col[i] == m_bar) caught++; else missed++;
                    m_valid[i] = 0;
                end else if (m_valid[i]) begin
                    m_row[i] = m_row[i] - 1;
                end
            end
        end
        for (int i = 0; i < ND; i++) begin
            if (!was_valid[i] && !done) begin
                done = 1; m_valid[i] = 1; m_row[i] = GS - 1; m_col[i] = int'(m_lfsr) % GS;
            end
        end
        if (l && !r && m_bar > 0) m_bar--;
        else if (r && !l && m_bar < GS - 1) m_bar++;
        ns = m_score + caught;
        if (ns > 255) ns = 255;
        if (ns != m_score && ns % 8 == 0 && m_period > 1) m_period--;
        m_score = ns;
        m_lives = (m_lives > missed) ? m_lives - missed : 0;
        if (m_lives == 0) m_dead = 1;
        if (m_dead) begin
            m_frame = XPAT;
        end else begin
            m_frame = 64'd1 << (m_bar * GS);
            for (int i = 0; i < ND; i++)
                if (m_valid[i]) m_frame = m_frame | (64'd1 << (m_col[i] * GS + m_row[i]));
        end
    endtask

    // One clock: drive inputs, queue the expectation if a step will be processed.
    task automatic tick(input logic e, input logic l, input logic r);
        exp_t x;
        e_act = e; left = l; right = r;
        if (e && !m_dead) begin
            model_step(l, r);
            x.frame = m_frame; x.score = 8'(m_score); x.lives = 4'(m_lives); x.dead = m_dead;
            sb.push_back(x);
        end
        m_lfsr = lfsr_next(m_lfsr);
        @(posedge clk);
        #1;
    endtask

    // Idle until the next spawn column does (or does not) match the bar.
    task automatic align(input bit want_match);
        bit empty;
        int n;
        empty = 0;
        for (int i = 0; i < ND; i++) if (!m_valid[i]) empty = 1;
        n = 0;
        while (empty && !m_dead && (((int'(m_lfsr) % GS) == m_bar) != want_match) && n < 300) begin
            tick(0, 0, 0);
            n++;
        end
        checks++;
        if (n >= 300) begin
            errors++; $display("FAIL align_timeout: idled %0d cycles, required < 300", n);
        end
    endtask

    task automatic reset_game();
        e_act = 0; left = 0; right = 0;
        @(negedge clk);
        #1 reset_ni = 0;
        @(posedge clk);
        @(negedge clk);
        reset_ni = 1;
        model_reset();
    endtask

    always @(negedge clk) begin
        if (reset_ni && d_act_o) begin
            checks++;
            if (sb.size() == 0) begin
                errors++; $display("FAIL unexpected_d_act: got d_act_o=1 required 0");
            end else begin
                mon_x = sb.pop_front();
                checks += 4;
                if (matrix_o !== mon_x.frame) begin
                    errors++; $display("FAIL sb_frame: got %h required %h", matrix_o, mon_x.frame);
                end
                if (score_o !== mon_x.score) begin
                    errors++; $display("FAIL sb_score: got %0d required %0d", score_o, mon_x.score);
                end
                if (lives_o !== mon_x.lives) begin
                    errors++; $display("FAIL sb_lives: got %0d required %0d", lives_o, mon_x.lives);
                end
                if (dead_o !== mon_x.dead) begin
                    errors++; $display("FAIL sb_dead: got %0b required %0b", dead_o, mon_x.dead);
                end
            end
        end
    end

    task automatic test_reset();
        reset_game();
        checks += 5;
        if (matrix_o !== DIAG) begin errors++; $display("FAIL reset_matrix: got %h required %h", matrix_o, DIAG); end
        if (lives_o !== 4'd3) begin errors++; $display("FAIL reset_lives: got %0d required 3", lives_o); end
        if (score_o !== 8'd0) begin errors++; $display("FAIL reset_score: got %0d required 0", score_o); end
        if (d_act_o !== 1'b0) begin errors++; $display("FAIL reset_d_act: got %0b required 0", d_act_o); end
        if (dead_o !== 1'b0) begin errors++; $display("FAIL reset_dead: got %0b required 0", dead_o); end
        tick(0, 1, 0);
        tick(0, 0, 1);
        checks += 2;
        if (matrix_o !== DIAG) begin errors++; $display("FAIL idle_matrix: got %h required %h", matrix_o, DIAG); end
        if (d_act_o !== 1'b0) begin errors++; $display("FAIL idle_d_act: got %0b required 0", d_act_o); end
    endtask

    task automatic test_bar();
        reset_game();
        repeat (3) tick(1, 0, 1);
        checks++;
        if ((matrix_o & ROW0) !== 64'h0100000000000000) begin
            errors++; $display("FAIL bar_right_limit: got %h required %h", matrix_o & ROW0, 64'h0100000000000000);
        end
        repeat (7) tick(1, 1, 0);
        checks++;
        if ((matrix_o & ROW0) !== 64'h1) begin
            errors++; $display("FAIL bar_left_7: got %h required %h", matrix_o & ROW0, 64'h1);
        end
        tick(1, 1, 0);
        checks++;
        if ((matrix_o & ROW0) !== 64'h1) begin
            errors++; $display("FAIL bar_left_hold: got %h required %h", matrix_o & ROW0, 64'h1);
        end
        tick(1, 0, 1);
        tick(1, 1, 1);
        tick(1, 1, 1);
        checks++;
        if ((matrix_o & ROW0) !== 64'h100) begin
            errors++; $display("FAIL bar_both: got %h required %h", matrix_o & ROW0, 64'h100);
        end
    endtask

    task automatic test_catch();
        int n;
        reset_game();
        n = 0;
        while (m_score == 0 && n < 60) begin
            if (m_valid[0] && m_col[0] < m_bar)      tick(1, 1, 0);
            else if (m_valid[0] && m_col[0] > m_bar) tick(1, 0, 1);
            else                                     tick(1, 0, 0);
            n++;
        end
        checks += 3;
        if (n >= 60) begin errors++; $display("FAIL catch_timeout: got %0d steps required < 60", n); end
        if (score_o !== 8'd1) begin errors++; $display("FAIL catch_score: got %0d required 1", score_o); end
        if (lives_o !== 4'd3) begin errors++; $display("FAIL catch_lives: got %0d required 3", lives_o); end
        tick(1, 0, 0);
        checks++;
        if (((matrix_o >> (m_col[0] * GS + GS - 1)) & 64'd1) !== 64'd1) begin
            errors++; $display("FAIL slot_reused: got %h, required a drop at column %0d row 7", matrix_o, m_col[0]);
        end
    endtask

    task automatic test_speedup();
        int n;
        logic [63:0] old;
        reset_game();
        n = 0;
        while (m_score < 8 && n < 100) begin
            align(1);
            tick(1, 0, 0);
            n++;
        end
        checks += 3;
        if (n >= 100) begin errors++; $display("FAIL speedup_timeout: got %0d steps required < 100", n); end
        if (score_o !== 8'd8) begin errors++; $display("FAIL speedup_score: got %0d required 8", score_o); end
        if (lives_o !== 4'd3) begin errors++; $display("FAIL speedup_lives: got %0d required 3", lives_o); end
        repeat (2) begin
            align(1);
            tick(1, 0, 0);
        end
        for (int k = 0; k < 4; k++) begin
            old = m_frame;
            align(1);
            tick(1, 0, 0);
            checks++;
            if (((matrix_o ^ (old >> 1)) & MID) !== 64'd0) begin
                errors++; $display("FAIL sink_every_step: got %h required rows 1..6 of %h", matrix_o & MID, (old >> 1) & MID);
            end
        end
    endtask

    task automatic test_reset_mid_game();
        @(negedge clk);
        #2;
        e_act = 1; left = 1; reset_ni = 0;
        #1;
        checks += 5;
        if (matrix_o !== DIAG) begin errors++; $display("FAIL mid_reset_matrix: got %h required %h", matrix_o, DIAG); end
        if (score_o !== 8'd0) begin errors++; $display("FAIL mid_reset_score: got %0d required 0", score_o); end
        if (lives_o !== 4'd3) begin errors++; $display("FAIL mid_reset_lives: got %0d required 3", lives_o); end
        if (dead_o !== 1'b0) begin errors++; $display("FAIL mid_reset_dead: got %0b required 0", dead_o); end
        if (d_act_o !== 1'b0) begin errors++; $display("FAIL mid_reset_d_act: got %0b required 0", d_act_o); end
        @(posedge clk);
        @(negedge clk);
        reset_ni = 1;
        model_reset();
        tick(1, 0, 0);
        checks++;
        if (d_act_o !== 1'b1) begin errors++; $display("FAIL first_step: got d_act_o=%0b required 1", d_act_o); end
    endtask

    task automatic test_game_over();
        int n;
        reset_game();
        n = 0;
        while (!m_dead && n < 150) begin
            align(0);
            tick(1, 0, 0);
            n++;
        end
        checks += 5;
        if (n >= 150) begin errors++; $display("FAIL dead_timeout: got %0d steps required < 150", n); end
        if (dead_o !== 1'b1) begin errors++; $display("FAIL dead_flag: got %0b required 1", dead_o); end
        if (lives_o !== 4'd0) begin errors++; $display("FAIL dead_lives: got %0d required 0", lives_o); end
        if (matrix_o !== XPAT) begin errors++; $display("FAIL dead_frame: got %h required %h", matrix_o, XPAT); end
        if (score_o !== 8'd0) begin errors++; $display("FAIL dead_score: got %0d required 0", score_o); end
        tick(1, 1, 0);
        tick(1, 0, 1);
        tick(1, 1, 1);
        tick(0, 1, 0);
        checks += 5;
        if (matrix_o !== XPAT) begin errors++; $display("FAIL frozen_frame: got %h required %h", matrix_o, XPAT); end
        if (lives_o !== 4'd0) begin errors++; $display("FAIL frozen_lives: got %0d required 0", lives_o); end
        if (dead_o !== 1'b1) begin errors++; $display("FAIL frozen_dead: got %0b required 1", dead_o); end
        if (score_o !== 8'd0) begin errors++; $display("FAIL frozen_score: got %0d required 0", score_o); end
        if (d_act_o !== 1'b0) begin errors++; $display("FAIL frozen_d_act: got %0b required 0", d_act_o); end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_bar();
        test_catch();
        test_speedup();
        test_reset_mid_game();
        test_game_over();
        e_act = 0;
        @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++; $display("FAIL sb_pending: got %0d unmatched steps required 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
